// File: rtl/fifo_ctl_pkg.sv
// Shared FIFO-control definitions: FSM state encoding and default sizing constants.
package fifo_ctl_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned BURST_MAX_DEF = 4;
  localparam int unsigned BEAT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping mod N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  logic [IDX_W:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(N_REQ)) begin
        idx = idx - (IDX_W+1)'(N_REQ);
      end
      if (!any && req[idx[IDX_W-1:0]]) begin
        any      = 1'b1;
        pick_idx = idx[IDX_W-1:0];
      end
    end
    pick[pick_idx] = any;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers in bounded bursts,
// honouring full (stall in place) and almost-full (no new grant) back-pressure.
module fifo_wr_arbiter
  import fifo_ctl_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                    w_clk,
  input  logic                    c_reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       fifo_d_in,
  output logic                    fifo_w_en,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy
);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                busy_q, busy_d;

  logic [N_REQ-1:0]    pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   slot [N_REQ];
  logic                req_own_c;
  logic                write_c;
  logic                burst_end_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      slot[i] = req_data[i*int'(DATA_W) +: DATA_W];
    end
  end

  // Write datapath: purely from registered grant plus live request/full inputs.
  assign req_own_c   = req[owner_q];
  assign write_c     = (state_q == ST_BURST) && req_own_c && !fifo_full;
  assign burst_end_c = !req_own_c ||
                       (write_c && (req_last[owner_q] ||
                                    (beat_cnt_q == BEAT_W'(BURST_MAX - 1))));

  assign fifo_w_en = write_c;
  assign fifo_d_in = write_c ? slot[owner_q] : '0;
  assign ack       = gnt_q & req & {N_REQ{write_c}};
  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !fifo_almost_full) begin
          state_d    = ST_BURST;
          gnt_d      = pick;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_BURST: begin
        if (write_c) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
        // Last holder drops to lowest priority for the next arbitration.
        if (burst_end_c) begin
          state_d    = ST_GAP;
          gnt_d      = '0;
          busy_d     = 1'b0;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk or posedge c_reset) begin
    if (c_reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle expected {gnt,owner,busy,w_en,ack,d_in}
// tables, inputs driven just after negedge and outputs sampled 1 time unit later.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic            w_clk = 1'b0;
  logic            c_reset;
  logic [N-1:0]    req, req_last, gnt, ack;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   fifo_d_in;
  logic            fifo_w_en, fifo_full, fifo_almost_full, busy;
  logic [1:0]      owner;
  logic [19:0]     obs;
  int              n_checks = 0;
  int              n_fail   = 0;

  always #5 w_clk = ~w_clk;

  // Observation word: gnt[19:16] owner[15:14] busy[13] w_en[12] ack[11:8] d_in[7:0]
  assign obs = {gnt, owner, busy, fifo_w_en, ack, fifo_d_in};

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .BURST_MAX (4),
    .IDX_W     (2)
  ) dut (
    .w_clk            (w_clk),
    .c_reset          (c_reset),
    .req              (req),
    .req_data         (req_data),
    .req_last         (req_last),
    .gnt              (gnt),
    .ack              (ack),
    .fifo_d_in        (fifo_d_in),
    .fifo_w_en        (fifo_w_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .owner            (owner),
    .busy             (busy)
  );

  task automatic cyc();
    @(negedge w_clk);
  endtask

  task automatic pulse_reset();
    cyc();
    c_reset = 1'b1; req = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    cyc();
    c_reset = 1'b0;
  endtask

  task automatic test_reset();
    c_reset = 1'b1; req = 4'b1111; req_last = 4'b1111; req_data = 32'hAAAA_AAAA;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    cyc(); cyc();
    #1; n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", obs, 20'h0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      c_reset = 1'b0; req = '0; req_last = '0;
      #1; n_checks++;
      if (obs !== 20'h0) begin
        n_fail++; $display("FAIL reset_idle c%0d: got %h want %h", i, obs, 20'h0);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0]  rq [7];
    logic [3:0]  ls [7];
    logic [7:0]  d0 [7];
    logic [19:0] ex [7];
    rq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    ls = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    d0 = '{8'h11, 8'h11, 8'h12, 8'h13, 8'h00, 8'h00, 8'h00};
    ex = '{20'h0,
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h11},
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h12},
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h13},
           20'h0, 20'h0, 20'h0};
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc();
      req = rq[i]; req_last = ls[i]; req_data[7:0] = d0[i];
      #1; n_checks++;
      if (obs !== ex[i]) begin
        n_fail++; $display("FAIL single c%0d: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int          ord [5];
    int          b, p, o;
    logic [19:0] ex;
    ord = '{0, 1, 2, 3, 0};
    pulse_reset();
    req = 4'b1111; req_last = '0; req_data = 32'hA3A2_A1A0;
    // Six-cycle period per grant: IDLE arbitration, four writes, GAP.
    for (int k = 0; k < 29; k++) begin
      if (k > 0) cyc();
      b = k / 6; p = k % 6;
      if (p == 0) begin
        o  = (b == 0) ? 0 : ord[b-1];
        ex = {4'b0000, 2'(o), 14'h0};
      end else if (p == 5) begin
        o  = ord[b];
        ex = {4'b0000, 2'(o), 14'h0};
      end else begin
        o  = ord[b];
        ex = {4'(1 << o), 2'(o), 1'b1, 1'b1, 4'(1 << o), 8'(8'hA0 + o)};
      end
      #1; n_checks++;
      if (obs !== ex) begin
        n_fail++; $display("FAIL round_robin c%0d: got %h want %h", k, obs, ex);
      end
    end
    cyc();
    req = '0;
  endtask

  task automatic test_back_pressure();
    logic        fl [10];
    logic [7:0]  d2 [10];
    logic [3:0]  rq [10];
    logic [3:0]  ls [10];
    logic [19:0] ex [10];
    rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
           4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ls = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
           4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    fl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    d2 = '{8'h21, 8'h21, 8'h22, 8'h22, 8'h22, 8'h22, 8'h23, 8'h24, 8'h00, 8'h00};
    ex = '{20'h0,
           {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, 8'h21},
           {4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000, 8'h00},
           {4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000, 8'h00},
           {4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000, 8'h00},
           {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, 8'h22},
           {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, 8'h23},
           {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, 8'h24},
           {4'b0000, 2'd2, 14'h0},
           {4'b0000, 2'd2, 14'h0}};
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      req = rq[i]; req_last = ls[i]; fifo_full = fl[i]; req_data[23:16] = d2[i];
      #1; n_checks++;
      if (obs !== ex[i]) begin
        n_fail++; $display("FAIL back_pressure c%0d: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_full_last();
    logic        fl [5];
    logic [3:0]  rq [5];
    logic [19:0] ex [5];
    rq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    fl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{20'h0,
           {4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000, 8'h00},
           {4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000, 8'h00},
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h31},
           20'h0};
    pulse_reset();
    req_last = 4'b0001; req_data = 32'h0000_0031;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      req = rq[i]; fifo_full = fl[i];
      #1; n_checks++;
      if (obs !== ex[i]) begin
        n_fail++; $display("FAIL full_last c%0d: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_almost_full();
    logic        af [6];
    logic [3:0]  rq [6];
    logic [19:0] ex [6];
    rq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    af = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex = '{20'h0, 20'h0, 20'h0, 20'h0,
           {4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010, 8'h41},
           {4'b0000, 2'd1, 14'h0}};
    pulse_reset();
    req_last = 4'b0010; req_data = 32'h0000_4100;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      req = rq[i]; fifo_almost_full = af[i];
      #1; n_checks++;
      if (obs !== ex[i]) begin
        n_fail++; $display("FAIL almost_full c%0d: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_withdraw();
    logic [3:0]  rq [6];
    logic [19:0] ex [6];
    rq = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    ex = '{20'h0,
           {4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000, 8'h51},
           {4'b1000, 2'd3, 1'b1, 1'b0, 4'b0000, 8'h00},
           {4'b0000, 2'd3, 14'h0},
           {4'b0000, 2'd3, 14'h0},
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h50}};
    pulse_reset();
    req_last = '0; req_data = 32'h5100_0050;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      req = rq[i];
      #1; n_checks++;
      if (obs !== ex[i]) begin
        n_fail++; $display("FAIL withdraw c%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    cyc();
    req = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0]  rq [8];
    logic [3:0]  ls [8];
    logic [31:0] dt [8];
    logic [19:0] ex [8];
    rq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0101, 4'b0101};
    ls = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    dt = '{32'h0000_0061, 32'h0000_0061, 32'h0000_7100, 32'h0000_7100,
           32'h0000_7100, 32'h0000_7200, 32'h0091_0081, 32'h0091_0081};
    ex = '{20'h0,
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h61},
           20'h0, 20'h0,
           {4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010, 8'h71},
           {4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010, 8'h72},
           20'h0,
           {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h81}};
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      if (i == 6) c_reset = 1'b0;
      req = rq[i]; req_last = ls[i]; req_data = dt[i];
      #1; n_checks++;
      if (obs !== ex[i]) begin
        n_fail++; $display("FAIL reset_mid c%0d: got %h want %h", i, obs, ex[i]);
      end
      // Asynchronous reset mid-cycle during the second beat must kill the write at once.
      if (i == 5) begin
        #1 c_reset = 1'b1;
        #1; n_checks++;
        if (obs !== 20'h0) begin
          n_fail++; $display("FAIL reset_mid_async: got %h want %h", obs, 20'h0);
        end
      end
    end
    cyc();
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_full_last();
    test_almost_full();
    test_withdraw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
